// File: rtl/ycfg_pkg.sv
// Shared types and helpers for the ycell configuration loader.
package ycfg_pkg;

  localparam int unsigned CELLS_DEF      = 4;
  localparam int unsigned BPC_DEF        = 2;
  localparam int unsigned WORD_W_DEF     = 8;
  localparam int unsigned CLR_CYCLES_DEF = 4;
  localparam int unsigned CHAIN_BITS     = CELLS_DEF * BPC_DEF;

  typedef enum logic [2:0] {
    IDLE, CLEAR, WAIT, SHIFT, RELEASE, DONE
  } state_e;

  typedef enum logic [1:0] {
    SETUP, STROBE, HOLD
  } phase_e;

  function automatic int unsigned words_per_load(input int unsigned cells,
                                                 input int unsigned bpc,
                                                 input int unsigned word_w);
    return (cells * bpc) / word_w;
  endfunction

endpackage

// File: rtl/ycfg_serializer.sv
// Word shift register and 3-phase confclk strobe generator for the ycell chain.
// YCFG_READBACK_EN adds capture of the chain tail into rb_word.
module ycfg_serializer
  import ycfg_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  output logic              cbitin,
  output logic              confclk,
  output logic              last_bit_c
`ifdef YCFG_READBACK_EN
  ,
  input  logic              cbitout_tail,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
`endif
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              active;
  phase_e            phase;

  assign last_bit_c = active && (phase == HOLD) && (bit_cnt == CNT_W'(WORD_W - 1));

  // cbitin is only updated at the SETUP boundary so it is stable across the strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      sr      <= '0;
      bit_cnt <= '0;
      active  <= 1'b0;
      phase   <= SETUP;
      cbitin  <= 1'b0;
      confclk <= 1'b0;
    end else if (load) begin
      sr      <= word;
      bit_cnt <= '0;
      active  <= 1'b1;
      phase   <= SETUP;
      cbitin  <= word[0];
      confclk <= 1'b0;
    end else if (active) begin
      case (phase)
        SETUP: begin
          phase   <= STROBE;
          confclk <= 1'b1;
        end
        STROBE: begin
          phase   <= HOLD;
          confclk <= 1'b0;
        end
        HOLD: begin
          phase <= SETUP;
          sr    <= {1'b0, sr[WORD_W-1:1]};
          if (last_bit_c) begin
            bit_cnt <= '0;
            active  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            cbitin  <= sr[1];
          end
        end
        default: phase <= SETUP;
      endcase
    end
  end

`ifdef YCFG_READBACK_EN
  // Tail bit is taken while confclk is high, before the chain advances
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_word  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= last_bit_c;
      if (active && (phase == STROBE)) begin
        rb_word <= {cbitout_tail, rb_word[WORD_W-1:1]};
      end
    end
  end
`endif

endmodule

// File: rtl/ycfg_loader.sv
// Configuration sequencer for a ycell chain: clear, serialise host words, release.
// YCFG_READBACK_EN enables destructive readback of the previous configuration.
module ycfg_loader
  import ycfg_pkg::*;
#(
  parameter int unsigned CELLS      = CELLS_DEF,
  parameter int unsigned BPC        = BPC_DEF,
  parameter int unsigned WORD_W     = WORD_W_DEF,
  parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cell_reset,
  output logic              confclk,
  output logic              cbitin,
  input  logic              cbitout_tail,
  output logic              busy,
  output logic              done
`ifdef YCFG_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
`endif
);

  localparam int unsigned WORDS  = words_per_load(CELLS, BPC, WORD_W);
  localparam int unsigned WCNT_W = $clog2(WORDS + 1);
  localparam int unsigned CCNT_W = $clog2(CLR_CYCLES + 1);

  if (((CELLS * BPC) % WORD_W) != 0 || WORDS < 1 || CLR_CYCLES < 1 || WORD_W < 2) begin : g_bad_cfg
    $error("ycfg_loader: CELLS*BPC must be a nonzero multiple of WORD_W (>=2), CLR_CYCLES >= 1");
  end

`ifdef YCFG_READBACK_EN
  localparam state_e LOAD_ENTRY = WAIT;
`else
  localparam state_e LOAD_ENTRY = CLEAR;
  logic unused_tail;
  assign unused_tail = cbitout_tail;
`endif

  state_e             state, state_nxt;
  logic [CCNT_W-1:0]  clr_cnt;
  logic [WCNT_W-1:0]  word_cnt, word_cnt_inc;
  logic               handshake, last_bit_c, last_word;
  logic               cell_reset_d, busy_d, done_d, word_ready_d;

  assign handshake    = word_valid && word_ready;
  assign word_cnt_inc = word_cnt + WCNT_W'(1);
  assign last_word    = (word_cnt_inc == WCNT_W'(WORDS));

  ycfg_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk          (clk),
    .reset        (reset),
    .load         (handshake),
    .word         (word_in),
    .cbitin       (cbitin),
    .confclk      (confclk),
    .last_bit_c   (last_bit_c)
`ifdef YCFG_READBACK_EN
    ,
    .cbitout_tail (cbitout_tail),
    .rb_word      (rb_word),
    .rb_valid     (rb_valid)
`endif
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = LOAD_ENTRY;
      CLEAR:      if (clr_cnt == CCNT_W'(CLR_CYCLES - 1)) state_nxt = WAIT;
      WAIT:       if (handshake) state_nxt = SHIFT;
      SHIFT:      if (last_bit_c) state_nxt = last_word ? RELEASE : WAIT;
      RELEASE:    state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs track it
  always_comb begin
    cell_reset_d = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    word_ready_d = 1'b0;
    case (state_nxt)
      CLEAR, SHIFT: busy_d = 1'b1;
      WAIT: begin
        busy_d       = 1'b1;
        word_ready_d = 1'b1;
      end
      RELEASE: cell_reset_d = 1'b0;
      DONE: begin
        cell_reset_d = 1'b0;
        done_d       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cell_reset <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      word_ready <= 1'b0;
    end else begin
      cell_reset <= cell_reset_d;
      busy       <= busy_d;
      done       <= done_d;
      word_ready <= word_ready_d;
    end
  end

  // Clear-wait and word counters
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      clr_cnt <= (state == CLEAR) ? clr_cnt + CCNT_W'(1) : '0;
      if ((state == IDLE || state == DONE) && start) word_cnt <= '0;
      else if (last_bit_c)                           word_cnt <= word_cnt_inc;
    end
  end

endmodule

// File: tb/tb_ycfg_loader.sv
// Directed bench for ycfg_loader: default 8-bit build plus a WORD_W=4 instance.
module tb_ycfg_loader;

`ifdef YCFG_READBACK_EN
  localparam int CLR = 0;
`else
  localparam int CLR = 4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_start, a_word_valid, a_word_ready, a_cell_reset, a_confclk, a_cbitin, a_busy, a_done;
  logic [7:0] a_word_in;
  logic [7:0] a_chain = 8'h00;
  logic       a_tail;
  logic       b_start, b_word_valid, b_word_ready, b_cell_reset, b_confclk, b_cbitin, b_busy, b_done;
  logic [3:0] b_word_in;
  logic       b_tail = 1'b0;
`ifdef YCFG_READBACK_EN
  logic [7:0] a_rb_word;
  logic       a_rb_valid;
  logic [3:0] b_rb_word;
  logic       b_rb_valid;
`endif

  int checks = 0;
  int errors = 0;

  ycfg_loader #(.CELLS(4), .BPC(2), .WORD_W(8), .CLR_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .word_in(a_word_in), .word_valid(a_word_valid),
    .word_ready(a_word_ready), .cell_reset(a_cell_reset), .confclk(a_confclk), .cbitin(a_cbitin),
    .cbitout_tail(a_tail), .busy(a_busy), .done(a_done)
`ifdef YCFG_READBACK_EN
    , .rb_word(a_rb_word), .rb_valid(a_rb_valid)
`endif
  );

  ycfg_loader #(.CELLS(4), .BPC(2), .WORD_W(4), .CLR_CYCLES(4)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .word_in(b_word_in), .word_valid(b_word_valid),
    .word_ready(b_word_ready), .cell_reset(b_cell_reset), .confclk(b_confclk), .cbitin(b_cbitin),
    .cbitout_tail(b_tail), .busy(b_busy), .done(b_done)
`ifdef YCFG_READBACK_EN
    , .rb_word(b_rb_word), .rb_valid(b_rb_valid)
`endif
  );

  // Four 2-bit ycells modelled as one shift chain advancing as confclk falls
  assign a_tail = a_chain[7];
  always @(negedge a_confclk) begin
    if (!reset) a_chain <= {a_chain[6:0], a_cbitin};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load on instance A; times are edges after the start edge
  task automatic run_a(output int lat, output logic [7:0] bits, output int pulses,
                       output int first_ready, output int cr_low, output logic first_crb,
                       output int rb_n, output logic [7:0] rb_w);
    lat = -1; bits = '0; pulses = 0; first_ready = -1; cr_low = -1; first_crb = 1'b0;
    rb_n = 0; rb_w = '0;
    a_start = 1'b1;
    for (int cyc = 1; cyc <= 200 && lat < 0; cyc++) begin
      tick();
      a_start = 1'b0;
      if (cyc == 1) first_crb = a_cell_reset & a_busy;
      if (a_word_ready && first_ready < 0) first_ready = cyc - 1;
      if (!a_cell_reset && cr_low < 0) cr_low = cyc - 1;
      if (a_confclk) begin
        if (pulses < 8) bits[pulses] = a_cbitin;
        pulses++;
      end
`ifdef YCFG_READBACK_EN
      if (a_rb_valid) begin
        rb_n++;
        rb_w = a_rb_word;
      end
`endif
      if (a_done) lat = cyc - 1;
    end
  endtask

  // Two-word load on instance B, optional valid gap and stray start pulses
  task automatic run_b(input int gap, input bit poke, output int lat, output logic [7:0] bits);
    int  hs_cnt, gap_left, pulses;
    bit  hs, poked_shift, poked_wait;
    lat = -1; bits = '0; pulses = 0; hs_cnt = 0; gap_left = gap;
    poked_shift = 1'b0; poked_wait = 1'b0;
    b_word_in = 4'h3; b_word_valid = 1'b1; b_start = 1'b1;
    for (int cyc = 1; cyc <= 300 && lat < 0; cyc++) begin
      hs = b_word_ready && b_word_valid;
      tick();
      b_start = 1'b0;
      if (hs) begin
        hs_cnt++;
        if (hs_cnt == 1) begin
          b_word_in = 4'hC;
          if (gap > 0) b_word_valid = 1'b0;
        end
      end else if (!b_word_valid && b_word_ready) begin
        if (gap_left == 0) b_word_valid = 1'b1;
        else begin
          chk("gap_confclk", 32'(b_confclk), 32'h0);
          gap_left--;
          if (poke && !poked_wait) begin
            b_start = 1'b1;
            poked_wait = 1'b1;
          end
        end
      end
      if (b_confclk) begin
        if (pulses < 8) bits[pulses] = b_cbitin;
        pulses++;
        if (poke && !poked_shift) begin
          b_start = 1'b1;
          poked_shift = 1'b1;
        end
      end
      if (b_done) lat = cyc - 1;
    end
    chk("b_pulses", 32'(pulses), 32'd8);
  endtask

  int         lat, pulses, first_ready, cr_low, rb_n, n;
  logic [7:0] bits, rb_w;
  logic       first_crb;

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_word_in = '0; a_word_valid = 1'b0;
    b_start = 1'b0; b_word_in = '0; b_word_valid = 1'b0;
    repeat (3) tick();
    chk("rst_cell_reset", 32'(a_cell_reset), 32'h1);
    chk("rst_confclk", 32'(a_confclk), 32'h0);
    chk("rst_cbitin", 32'(a_cbitin), 32'h0);
    chk("rst_word_ready", 32'(a_word_ready), 32'h0);
    chk("rst_busy", 32'(a_busy), 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);
    reset = 1'b0;
    tick();

    // Single-word load of 8'hB4 with valid held high
    a_word_in = 8'hB4; a_word_valid = 1'b1;
    run_a(lat, bits, pulses, first_ready, cr_low, first_crb, rb_n, rb_w);
    chk("t1_first_busy", 32'(first_crb), 32'h1);
    chk("t1_clear_len", 32'(first_ready), 32'(CLR));
    chk("t1_bits", 32'(bits), 32'hB4);
    chk("t1_pulses", 32'(pulses), 32'd8);
    chk("t1_latency", 32'(lat), 32'(CLR + 26));
    chk("t1_release", 32'(cr_low), 32'(CLR + 25));
    chk("t1_chain", 32'(a_chain), 32'h2D);
    tick();
    chk("t1_done_hold", 32'(a_done), 32'h1);
    chk("t1_cell_reset", 32'(a_cell_reset), 32'h0);
    chk("t1_busy", 32'(a_busy), 32'h0);

    // WORD_W=4: words 3 then C, without and with a 10-cycle valid gap
    run_b(0, 1'b0, lat, bits);
    chk("t2_bits", 32'(bits), 32'hC3);
    chk("t2_latency", 32'(lat), 32'(CLR + 27));
    run_b(10, 1'b0, lat, bits);
    chk("t2g_bits", 32'(bits), 32'hC3);
    chk("t2g_latency", 32'(lat), 32'(CLR + 37));
    chk("t2g_ready", 32'(b_word_ready), 32'h0);

    // Stray start pulses during SHIFT and WAIT
    run_b(10, 1'b1, lat, bits);
    chk("t4_bits", 32'(bits), 32'hC3);
    chk("t4_latency", 32'(lat), 32'(CLR + 37));

    // Reset asserted during the 5th STROBE
    n = 0;
    a_start = 1'b1;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      tick();
      a_start = 1'b0;
      if (a_confclk) n++;
    end
    chk("t3_reached_strobe5", 32'(n), 32'd5);
    reset = 1'b1;
    tick();
    chk("t3_confclk", 32'(a_confclk), 32'h0);
    chk("t3_cell_reset", 32'(a_cell_reset), 32'h1);
    chk("t3_busy", 32'(a_busy), 32'h0);
    chk("t3_done", 32'(a_done), 32'h0);
    reset = 1'b0;
    tick();
    run_a(lat, bits, pulses, first_ready, cr_low, first_crb, rb_n, rb_w);
    chk("t3_reload_bits", 32'(bits), 32'hB4);
    chk("t3_reload_latency", 32'(lat), 32'(CLR + 26));
    chk("t3_chain", 32'(a_chain), 32'h2D);

    // Reload from DONE with 8'h5A
    a_word_in = 8'h5A;
    run_a(lat, bits, pulses, first_ready, cr_low, first_crb, rb_n, rb_w);
    chk("t5_first_busy", 32'(first_crb), 32'h1);
    chk("t5_bits", 32'(bits), 32'h5A);
    chk("t5_latency", 32'(lat), 32'(CLR + 26));
    chk("t5_chain", 32'(a_chain), 32'h5A);
`ifdef YCFG_READBACK_EN
    chk("rb_pulses", 32'(rb_n), 32'd1);
    chk("rb_word", 32'(rb_w), 32'hB4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ycfg_loader.md
Name: ycfg_loader

Overview:
- Configuration sequencer for a chain of Morphle Logic yellow cells (ycell) linked cbitout->cbitin.
- Takes configuration words from a host over a valid/ready handshake and holds the cell array in reset while it clears.
- Serialises the words onto the chain's cbitin with confclk strobes, then releases the array.
- Sits between the host/bus interface and the head cell of one ycell column or row.

Parameters:
- CELLS, 4, number of ycells in the chain.
- BPC, 2, configuration bits per cell.
- WORD_W, 8, host word width. CELLS*BPC must be a multiple of WORD_W; this is checked at elaboration.
- CLR_CYCLES, 4, cycles cell_reset is held high before shifting starts. Minimum 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load. Ignored unless the block is in IDLE or DONE.
- word_in  in  WORD_W  configuration word. Bit 0 is shifted first.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  loader accepts word_in this cycle.
- cell_reset  out  1  reset to every ycell in the chain.
- confclk  out  1  configuration strobe to the chain.
- cbitin  out  1  serial configuration bit to the head cell.
- cbitout_tail  in  1  cbitout of the last cell in the chain.
- busy  out  1  a load is in progress.
- done  out  1  the last load completed. Stays high until the next start or reset.

Behaviour:
- Reset values: cell_reset=1 (array frozen), confclk=0, cbitin=0, word_ready=0, busy=0, done=0. State is IDLE and all counters are 0.
- States and transitions:
  - IDLE/DONE -> CLEAR on start.
  - CLEAR -> WAIT after CLR_CYCLES cycles with cell_reset=1.
  - WAIT -> SHIFT on a word handshake.
  - SHIFT -> WAIT after WORD_W bits, if more words remain.
  - SHIFT -> RELEASE after the final bit.
  - RELEASE -> DONE.
- CLEAR: cell_reset=1, busy=1, done=0. A start pulse during CLEAR, WAIT or SHIFT is ignored.
- WAIT:
  - word_ready=1; the word is captured when word_valid and word_ready are both high.
  - word_ready is 0 in every other state; no skid buffer.
  - The host may hold word_valid low indefinitely. confclk stays 0 and cbitin holds its last value.
- SHIFT: each bit takes 3 cycles.
  - SETUP: cbitin=bit, confclk=0.
  - STROBE: confclk=1, cbitin held.
  - HOLD: confclk=0, cbitin held.
  - Bit order is LSB first within a word, words in arrival order. The first bit sent ends up in the last cell.
  - cell_reset stays 1 for the whole of SHIFT.
- Total load latency from start to done rising: CLR_CYCLES + 3*CELLS*BPC + (number of WORD handshakes, at 1 cycle each when valid is already high) + 1 (RELEASE).
- RELEASE: cell_reset->0 and busy->0 in the same cycle. done->1 on the following edge.
- Counters:
  - The bit counter is $clog2(WORD_W) wide and wraps to 0 at the end of each word.
  - The word counter is $clog2(CELLS*BPC/WORD_W + 1) wide and never wraps; completion is exact at CELLS*BPC/WORD_W.
- Reset mid-load: returns to reset values immediately, with cell_reset=1. A partial configuration is never released.
- Reload from DONE: start re-enters CLEAR. cell_reset rises in the same cycle as busy.

Optional Feature:
- Macro: YCFG_READBACK_EN.
- With the macro defined:
  - Extra ports rb_word (out, WORD_W) and rb_valid (out, 1).
  - cbitout_tail is sampled in each STROBE cycle, before the edge, and shifted into rb_word LSB first.
  - rb_valid pulses for 1 cycle after each word's HOLD of its last bit.
  - The host therefore reads back the previous configuration, which is destructive shifting.
  - CLEAR is skipped: cell_reset is held high but the wait is 0 cycles, so old bits survive.
- Without the macro: no readback ports, no sampling logic, and cbitout_tail is unused.

Decomposition:
- Package ycfg_pkg holds:
  - the state enum (IDLE, CLEAR, WAIT, SHIFT, RELEASE, DONE);
  - the phase enum (SETUP, STROBE, HOLD);
  - the localparam CHAIN_BITS = CELLS*BPC and the words-per-load function.
- One sub-module, ycfg_serializer: a WORD_W shift register plus the 3-phase strobe generator. It has load/accept and last-bit outputs. The FSM stays in ycfg_loader.

Test Plan:
- Defaults, word_in=8'hB4 held valid, start pulse:
  - cell_reset=1 for 4 cycles, then 8 confclk pulses with cbitin sequence 0,0,1,0,1,1,0,1;
  - done rises 30 cycles after start, then cell_reset=0.
  - Feed the outputs into 4 ycells and check the stored config via each cell's cbitout.
- WORD_W=4, words 4'h3 then 4'hC, with word_valid low for 10 cycles between them:
  - word_ready stays high and confclk stays 0 during the gap;
  - cbitin sequence 1,1,0,0,0,0,1,1;
  - done arrives 10 cycles later than with no gap.
- Assert reset during the 5th STROBE:
  - the next cycle gives confclk=0, cell_reset=1, busy=0, done=0;
  - a fresh start then performs a complete load.
- start pulsed during SHIFT and again during WAIT: ignored, and the bit count and timing are unchanged.
- With YCFG_READBACK_EN, load 8'hB4 then load 8'h5A: the second load gives rb_word=8'hB4 with one rb_valid pulse.
